// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the CPU-side RAM initiator.
// Contents: RAM geometry reused by the RAM and the datapath, the 2-bit
// controller state encodings, and the legal strobe-dwell limit.
package mem_access_ctrl_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 8;

    // Longest strobe dwell the controller accepts, in clock cycles.
    localparam int STROBE_MAX = 15;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_SETUP  = S_SETUP,
        ST_STROBE = S_STROBE,
        ST_DONE   = S_DONE
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_strobe_timer.sv
// strobe_timer: loadable down-counter that times the RAM strobe dwell.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset (count -> 0)
//   i_load     load i_load_val on the next edge (wins over i_dec)
//   i_load_val value to load
//   i_dec      decrement on the next edge; holds at zero
//   o_zero     high while the count is zero
module strobe_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] r_count;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= CNT_ZERO;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != CNT_ZERO)) begin
            r_count <= r_count - CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == CNT_ZERO);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side initiator for the word RAM. Takes one read or
// write request at a time, holds address/data stable, issues a clean strobe
// of STROBE_CYCLES cycles, captures read data and pulses done.
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   req, we, addr, wdata request from the control unit (sampled in IDLE)
//   busy                high whenever the controller is not IDLE
//   done                one-cycle completion pulse
//   rdata               last word read; held between reads
//   ram_address, ram_data_in, ram_write, ram_read  to the RAM
//   ram_data_out        from the RAM
// All outputs come straight from registers.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W        = MEM_DATA_W,
    parameter int ADDR_W        = MEM_ADDR_W,
    parameter int STROBE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write,
    output logic              ram_read,
    input  logic [DATA_W-1:0] ram_data_out
);

    if ((STROBE_CYCLES < 1) || (STROBE_CYCLES > STROBE_MAX)) begin : g_bad_strobe
        $error("mem_access_ctrl: STROBE_CYCLES=%0d outside 1..%0d", STROBE_CYCLES, STROBE_MAX);
    end

    if (STROBE_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_cnt_w
        $error("mem_access_ctrl: CNT_W=%0d cannot hold STROBE_CYCLES=%0d", CNT_W, STROBE_CYCLES);
    end

    // Counter starts at dwell-1 so the strobe drops on the edge it reads zero.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STROBE_CYCLES - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic                r_op_we;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_ram_address;
    logic [DATA_W-1:0]   r_ram_data_in;
    logic                r_ram_write;
    logic                r_ram_read;
    logic                w_load;
    logic                w_dec;
    logic                w_cnt_zero;
    logic                w_accept;
    logic                w_capture;

    strobe_timer #(
        .CNT_W (CNT_W)
    ) u_strobe_timer (
        .clk        (clk),
        .clr        (clr),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and timer control.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next_state = ST_SETUP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_next_state = ST_STROBE;
                w_load       = 1'b1;
            end
            ST_STROBE: begin
                w_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_STROBE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_capture = (r_state == ST_STROBE) && w_cnt_zero && !r_op_we;

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state they describe without any output glitching.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= ST_IDLE;
            r_op_we       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rdata       <= '0;
            r_ram_address <= '0;
            r_ram_data_in <= '0;
            r_ram_write   <= 1'b0;
            r_ram_read    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
            r_ram_write <= (w_next_state == ST_STROBE) && r_op_we;
            r_ram_read  <= (w_next_state == ST_STROBE) && !r_op_we;
            // Address/data only move at acceptance, never under a strobe.
            if (w_accept) begin
                r_op_we       <= we;
                r_ram_address <= addr;
                r_ram_data_in <= wdata;
            end else begin
                r_op_we       <= r_op_we;
                r_ram_address <= r_ram_address;
                r_ram_data_in <= r_ram_data_in;
            end
            if (w_capture) begin
                r_rdata <= ram_data_out;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign ram_address = r_ram_address;
    assign ram_data_in = r_ram_data_in;
    assign ram_write   = r_ram_write;
    assign ram_read    = r_ram_read;

endmodule
